mfm_write_encoder: RTL and testbench

MFM_WRITE_ENCODER -- requirements
Module: mfm_write_encoder

---
 rtl/mfm_write_encoder.sv | 154 +++++++++++++++
 tb/tb_mfm_write_encoder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mfm_write_encoder.sv
// MFM write encoder: one-word holding register feeding a shifter, MSB-first cells of 2*HALF_CELL clocks.
// flux/pulse registered one clock after the deciding cycle; ready is holding-empty, back-to-back words with no gap.
module mfm_write_encoder #(
    parameter int HALF_CELL = 4,
    parameter int WIDTH     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] data,
    input  logic             valid,
    output logic             ready,
    output logic             flux,
    output logic             pulse,
    output logic             busy,
    output logic             underrun
);
    localparam int              IW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]      CNT_LAST = 8'(HALF_CELL - 1);
    localparam logic [IW-1:0]   IDX_TOP  = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLK_HALF  = 2'd1,
        DATA_HALF = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             prev_q, prev_d;
    logic             flux_q, flux_d;
    logic             pulse_q, pulse_d;
    logic             underrun_q, underrun_d;

    logic cur_bit;
    logic cnt_wrap;
    logic accept;

    assign cur_bit  = shift_q[WIDTH-1];
    assign cnt_wrap = (cnt_q == CNT_LAST);
    assign accept   = valid && !hold_full_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        idx_d       = idx_q;
        prev_d      = prev_q;
        flux_d      = flux_q;
        pulse_d     = 1'b0;
        underrun_d  = underrun_q && en;

        // Accept only into an empty holding register, so it never collides with a reload.
        if (accept) begin
            hold_d      = data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (en && hold_full_q) begin
                    state_d     = CLK_HALF;
                    cnt_d       = '0;
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    idx_d       = IDX_TOP;
                    prev_d      = 1'b0;
                end
            end
            CLK_HALF: begin
                if (cnt_q == '0 && !cur_bit && !prev_q) begin
                    flux_d  = ~flux_q;
                    pulse_d = 1'b1;
                end
                if (cnt_wrap) begin
                    state_d = DATA_HALF;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DATA_HALF: begin
                if (cnt_q == '0 && cur_bit) begin
                    flux_d  = ~flux_q;
                    pulse_d = 1'b1;
                end
                if (cnt_wrap) begin
                    cnt_d  = '0;
                    prev_d = cur_bit;
                    if (idx_q != '0) begin
                        shift_d = shift_q << 1;
                        idx_d   = idx_q - 1'b1;
                        state_d = CLK_HALF;
                    end else if (en && hold_full_q) begin
                        // Seamless reload: prev-bit carries across the word boundary.
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        idx_d       = IDX_TOP;
                        state_d     = CLK_HALF;
                    end else begin
                        state_d = IDLE;
                        if (en) begin
                            underrun_d = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            idx_q       <= '0;
            prev_q      <= 1'b0;
            flux_q      <= 1'b0;
            pulse_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            idx_q       <= idx_d;
            prev_q      <= prev_d;
            flux_q      <= flux_d;
            pulse_q     <= pulse_d;
            underrun_q  <= underrun_d;
        end
    end

    assign ready    = !hold_full_q;
    assign busy     = (state_q != IDLE);
    assign flux     = flux_q;
    assign pulse    = pulse_q;
    assign underrun = underrun_q;

endmodule

// File: tb/tb_mfm_write_encoder.sv
// Directed bench for mfm_write_encoder: an MFM bit-stream model predicts every pulse/flux cycle,
// plus hand-computed pulse counts, ready/busy/underrun points and reset behaviour.
module tb_mfm_write_encoder;
    localparam int H    = 4;
    localparam int W    = 16;
    localparam int NCYC = 4096;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] data;
    logic         valid;
    logic         ready;
    logic         flux;
    logic         pulse;
    logic         busy;
    logic         underrun;

    mfm_write_encoder #(.HALF_CELL(H), .WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .data     (data),
        .valid    (valid),
        .ready    (ready),
        .flux     (flux),
        .pulse    (pulse),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    bit   exp_pulse [NCYC];
    bit   exp_rstmk [NCYC];
    int   cyc    = 0;
    int   nvec   = 0;
    int   nfail  = 0;
    int   npulse = 0;
    logic exp_flux = 1'b0;
    bit   chk_on = 1'b0;
    logic mprev;
    int   mcount;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        nvec++;
        if (act !== expv) begin
            nfail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, expv);
        end
    endtask

    // One clock: outputs sampled 1 time unit after the rising edge, stimulus applied at the falling edge.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (chk_on && cyc < NCYC) begin
            if (exp_rstmk[cyc]) exp_flux = 1'b0;
            else if (exp_pulse[cyc]) exp_flux = ~exp_flux;
            check("pulse", {31'd0, pulse}, {31'd0, exp_pulse[cyc]});
            check("flux", {31'd0, flux}, {31'd0, exp_flux});
            if (pulse === 1'b1) npulse++;
        end
        @(negedge clk);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // MFM rule on the bit stream: clock-half transition for a 0 after a 0, data-half transition for a 1.
    // t0 is the cycle on which cell 0's clock-half transition would be visible.
    task automatic model_word(input int t0, input logic [W-1:0] w);
        for (int k = 0; k < W; k++) begin
            logic b;
            b = w[W-1-k];
            if (!b && !mprev) begin
                exp_pulse[t0 + 2*H*k] = 1'b1;
                mcount++;
            end
            if (b) begin
                exp_pulse[t0 + 2*H*k + H] = 1'b1;
                mcount++;
            end
            mprev = b;
        end
    endtask

    task automatic model_reset(input int c);
        for (int i = c; i < NCYC; i++) exp_pulse[i] = 1'b0;
        exp_rstmk[c] = 1'b1;
    endtask

    task automatic present(input logic [W-1:0] w);
        valid = 1'b1;
        data  = w;
        tick();
        valid = 1'b0;
    endtask

    task automatic clear_underrun();
        en = 1'b0;
        tick();
        check("underrun_clear", {31'd0, underrun}, 32'd0);
        en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int p0;
        rst   = 1'b1;
        en    = 1'b0;
        valid = 1'b0;
        data  = '0;
        repeat (3) tick();
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flux", {31'd0, flux}, 32'd0);
        check("rst_pulse", {31'd0, pulse}, 32'd0);
        check("rst_underrun", {31'd0, underrun}, 32'd0);
        rst    = 1'b0;
        chk_on = 1'b1;

        // All ones: 16 data-half transitions, flux returns to 0.
        en = 1'b1;
        n = cyc; mprev = 1'b0; mcount = 0;
        model_word(n + 3, 16'hFFFF);
        check("model_ffff_count", mcount, 32'd16);
        p0 = npulse;
        present(16'hFFFF);
        check("ffff_ready_full", {31'd0, ready}, 32'd0);
        tick();
        check("ffff_ready_empty", {31'd0, ready}, 32'd1);
        check("ffff_busy", {31'd0, busy}, 32'd1);
        run_to(n + 129);
        check("ffff_busy_last", {31'd0, busy}, 32'd1);
        check("ffff_underrun_early", {31'd0, underrun}, 32'd0);
        tick();
        check("ffff_busy_end", {31'd0, busy}, 32'd0);
        check("ffff_underrun", {31'd0, underrun}, 32'd1);
        check("ffff_pulses", npulse - p0, 32'd16);
        check("ffff_flux_end", {31'd0, flux}, 32'd0);

        // Single leading one: 15 transitions, underrun set at word end.
        clear_underrun();
        n = cyc; mprev = 1'b0; mcount = 0;
        model_word(n + 3, 16'h8000);
        check("model_8000_count", mcount, 32'd15);
        p0 = npulse;
        present(16'h8000);
        run_to(n + 129);
        check("8000_underrun_early", {31'd0, underrun}, 32'd0);
        tick();
        check("8000_underrun", {31'd0, underrun}, 32'd1);
        check("8000_busy_end", {31'd0, busy}, 32'd0);
        check("8000_pulses", npulse - p0, 32'd15);
        check("8000_flux_end", {31'd0, flux}, 32'd1);

        // Back-to-back words: second cell 0 exactly 128 clocks after the first.
        clear_underrun();
        n = cyc; mprev = 1'b0; mcount = 0;
        model_word(n + 3, 16'h0000);
        model_word(n + 3 + 2*H*W, 16'hAAAA);
        check("model_0000_aaaa_count", mcount, 32'd24);
        p0 = npulse;
        present(16'h0000);
        tick();
        present(16'hAAAA);
        check("b2b_ready_held", {31'd0, ready}, 32'd0);
        run_to(n + 129);
        check("b2b_ready_before_reload", {31'd0, ready}, 32'd0);
        tick();
        check("b2b_ready_after_reload", {31'd0, ready}, 32'd1);
        check("b2b_busy_reload", {31'd0, busy}, 32'd1);
        run_to(n + 257);
        check("b2b_underrun_early", {31'd0, underrun}, 32'd0);
        tick();
        check("b2b_underrun", {31'd0, underrun}, 32'd1);
        check("b2b_busy_end", {31'd0, busy}, 32'd0);
        check("b2b_pulses", npulse - p0, 32'd24);

        // en dropped during bit 5: word completes, no underrun.
        clear_underrun();
        n = cyc; mprev = 1'b0; mcount = 0;
        model_word(n + 3, 16'h1234);
        check("model_1234_count", mcount, 32'd12);
        p0 = npulse;
        present(16'h1234);
        run_to(n + 45);
        en = 1'b0;
        run_to(n + 129);
        check("en_drop_busy_last", {31'd0, busy}, 32'd1);
        tick();
        check("en_drop_busy_end", {31'd0, busy}, 32'd0);
        check("en_drop_underrun", {31'd0, underrun}, 32'd0);
        check("en_drop_pulses", npulse - p0, 32'd12);

        // valid held while ready is low: third word must not replace the held one.
        en = 1'b1;
        n = cyc; mprev = 1'b0; mcount = 0;
        model_word(n + 3, 16'hF0F0);
        model_word(n + 3 + 2*H*W, 16'h0F0F);
        check("model_f0f0_0f0f_count", mcount, 32'd29);
        p0 = npulse;
        present(16'hF0F0);
        tick();
        valid = 1'b1;
        data  = 16'h0F0F;
        tick();
        data  = 16'hFFFF;
        run_to(n + 50);
        check("hold_ready_low", {31'd0, ready}, 32'd0);
        run_to(n + 100);
        valid = 1'b0;
        run_to(n + 258);
        check("hold_underrun", {31'd0, underrun}, 32'd1);
        check("hold_pulses", npulse - p0, 32'd29);

        // Reset mid-word with a word held; valid and en asserted alongside reset.
        clear_underrun();
        n = cyc; mprev = 1'b0; mcount = 0;
        model_word(n + 3, 16'h5555);
        present(16'h5555);
        tick();
        present(16'h1111);
        run_to(n + 60);
        model_reset(n + 61);
        rst   = 1'b1;
        valid = 1'b1;
        data  = 16'hFFFF;
        tick();
        rst   = 1'b0;
        valid = 1'b0;
        check("mid_rst_flux", {31'd0, flux}, 32'd0);
        check("mid_rst_pulse", {31'd0, pulse}, 32'd0);
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_underrun", {31'd0, underrun}, 32'd0);
        p0 = npulse;
        run_to(n + 261);
        check("post_rst_pulses", npulse - p0, 32'd0);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
